// File: rtl/rv_mem_pkg.sv
// Shared definitions for the MEM-stage data memory: RV32I access-size
// encodings, controller state type and a funct3 legality helper.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Stores have no unsigned variants; loads accept all five sizes.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables, replicated store data and
// extended load data for an RV32I access, plus misalign/illegal detection.
module dmem_lane_align
  import rv_mem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic        misalign;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    misalign = 1'b0;
    be_o     = '0;
    wdata_o  = wdata_i;
    rdata_o  = '0;
    rbyte    = 8'(rword_i >> {off_i, 3'b000});
    rhalf    = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = funct3_i[2] ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      2'b01: begin
        misalign = off_i[0];
        be_o     = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o  = {2{wdata_i[15:0]}};
        rdata_o  = funct3_i[2] ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      2'b10: begin
        misalign = (off_i != 2'b00);
        be_o     = 4'b1111;
        rdata_o  = rword_i;
      end
      default: ;
    endcase
    err_o = misalign | ~f3_legal(we_i, funct3_i);
    // Errors never touch the array and always return zero data.
    if (err_o | ~we_i) be_o = '0;
    if (err_o | we_i)  rdata_o = '0;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory with wait states and a valid/ready handshake.
// Optional performance counters are enabled by defining DMEM_PERF_CNT_EN.
module dmem_ctrl
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [3:0]  LAT    = 4'(LATENCY);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         mem_q [DEPTH];

  logic [ADDR_W-1:0]   idx;
  logic                access;
  logic [3:0]          be;
  logic [31:0]         wdata_al;
  logic [31:0]         rdata_d;
  logic                err_d;
  logic                unused_addr_hi;

  assign idx            = addr_q[ADDR_W+1:2];
  assign access         = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign stall          = (req_valid & ~req_ready) | (state_q == ST_BUSY);
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  dmem_lane_align u_align (
    .we_i     (we_q),
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rword_i  (mem_q[idx]),
    .be_o     (be),
    .wdata_o  (wdata_al),
    .rdata_o  (rdata_d),
    .err_o    (err_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        // req_ready is registered high in both of these states.
        ST_IDLE, ST_RESP: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            addr_q    <= req_addr[ADDR_W+1:0];
            wdata_q   <= req_wdata;
            cnt_q     <= LAT;
            state_q   <= ST_BUSY;
            req_ready <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q    <= ST_RESP;
            req_ready  <= 1'b1;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_d;
            resp_err   <= err_d;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Array is not reset; a reset during BUSY leaves the store uncommitted.
  always_ff @(posedge clk) begin
    if (access && we_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loads        <= '0;
      perf_stores       <= '0;
      perf_errs         <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (access) begin
        if (err_d)     perf_errs   <= perf_errs + 32'd1;
        else if (we_q) perf_stores <= perf_stores + 32'd1;
        else           perf_loads  <= perf_loads + 32'd1;
      end
      if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: instance 0 (LATENCY=0) and 1 (LATENCY=3)
// against a byte-array reference model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        rv   [2];
  logic        rr   [2];
  logic        we   [2];
  logic [2:0]  f3   [2];
  logic [31:0] ad   [2];
  logic [31:0] wd   [2];
  logic        rsv  [2];
  logic [31:0] rd   [2];
  logic        er   [2];
  logic        st   [2];
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] p_ld [2];
  logic [31:0] p_st [2];
  logic [31:0] p_er [2];
  logic [31:0] p_sc [2];
  int unsigned exp_ld = 0, exp_st = 0, exp_er = 0, exp_sc = 0;
`endif

  dmem_ctrl #(.DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_ready(rr[0]), .req_we(we[0]),
    .req_funct3(f3[0]), .req_addr(ad[0]), .req_wdata(wd[0]), .resp_valid(rsv[0]),
    .resp_rdata(rd[0]), .resp_err(er[0]), .stall(st[0])
`ifdef DMEM_PERF_CNT_EN
    , .perf_loads(p_ld[0]), .perf_stores(p_st[0]), .perf_errs(p_er[0]),
    .perf_stall_cycles(p_sc[0])
`endif
  );

  dmem_ctrl #(.DEPTH(256), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_ready(rr[1]), .req_we(we[1]),
    .req_funct3(f3[1]), .req_addr(ad[1]), .req_wdata(wd[1]), .resp_valid(rsv[1]),
    .resp_rdata(rd[1]), .resp_err(er[1]), .stall(st[1])
`ifdef DMEM_PERF_CNT_EN
    , .perf_loads(p_ld[1]), .perf_stores(p_st[1]), .perf_errs(p_er[1]),
    .perf_stall_cycles(p_sc[1])
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
  } exp_t;

  int          checks = 0, failures = 0;
  int unsigned cyc = 0;
  exp_t        sbq0[$], sbq1[$];
  logic [7:0]  mdl [2][1024];
  int unsigned nresp [2];
  logic [31:0] last_rd [2];
  logic        last_err [2];
  int unsigned rc1[$];
  int unsigned run1 = 0;
  bit          skip_run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference: byte-addressed little-endian memory, wrap at 4*DEPTH bytes.
  task automatic model(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wdat, output logic [31:0] r, output logic e);
    int unsigned b = a % 1024;
    int unsigned sz;
    r = '0;
    e = 1'b0;
    case (f)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (sz == 0 || (w && f[2])) e = 1'b1;
    else if (b % sz != 0)       e = 1'b1;
    if (e) return;
    if (w) begin
      for (int i = 0; i < int'(sz); i++) mdl[d][b+i] = wdat[8*i +: 8];
    end else begin
      for (int i = 0; i < int'(sz); i++) r[8*i +: 8] = mdl[d][b+i];
      if (!f[2] && sz < 4 && r[8*sz-1]) r = r | (32'hFFFF_FFFF << (8*sz));
    end
  endtask

  task automatic issue(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wdat, input bit track);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    we[d] = w; f3[d] = f; ad[d] = a; wd[d] = wdat; rv[d] = 1'b1;
    while (rr[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL accept_timeout dut=%0d actual=no_ready required=ready", d);
      rv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 rv[d] = 1'b0;
    if (track) begin
      model(d, w, f, a, wdat, e.rdata, e.err);
      e.acc = cyc;
      if (d == 0) sbq0.push_back(e);
      else        sbq1.push_back(e);
`ifdef DMEM_PERF_CNT_EN
      if (d == 0) begin
        if (e.err)  exp_er++;
        else if (w) exp_st++;
        else        exp_ld++;
      end
`endif
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq0.size() != 0 || sbq1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", sbq0.size(), sbq1.size());
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d] === 1'b0) begin
        chk($sformatf("stall_vs_busy%0d", d), {31'b0, st[d]}, {31'b0, ~rr[d]});
        if (rsv[d] === 1'b1) begin
          exp_t e;
          nresp[d]++;
          last_rd[d]  = rd[d];
          last_err[d] = er[d];
          if (d == 1) rc1.push_back(cyc);
          if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp dut=%0d actual=resp_valid required=idle", d);
          end else begin
            e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
            chk($sformatf("rdata%0d", d), rd[d], e.rdata);
            chk($sformatf("err%0d", d), {31'b0, er[d]}, {31'b0, e.err});
            chk($sformatf("latency%0d", d), cyc - e.acc, lat(d));
          end
        end
      end
    end
`ifdef DMEM_PERF_CNT_EN
    if (rst[0] === 1'b0 && st[0] === 1'b1) exp_sc++;
`endif
    if (rst[1] === 1'b0 && rr[1] === 1'b0) run1++;
    else begin
      if (run1 != 0 && !skip_run) chk("ready_low_run1", run1, 4);
      run1 = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [2:0]  lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [31:0] ra, rw;
  logic [2:0]  rf;
  logic        rwe;
  int unsigned n0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rv[d] = 1'b0; we[d] = 1'b0; f3[d] = '0; ad[d] = '0; wd[d] = '0;
      nresp[d] = 0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready%0d", d), {31'b0, rr[d]}, 32'd1);
      chk($sformatf("rst_valid%0d", d), {31'b0, rsv[d]}, 32'd0);
      chk($sformatf("rst_rdata%0d", d), rd[d], 32'd0);
      chk($sformatf("rst_err%0d", d), {31'b0, er[d]}, 32'd0);
      chk($sformatf("rst_stall%0d", d), {31'b0, st[d]}, 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int w = 0; w < 256; w++) issue(0, 1'b1, 3'd2, 32'(4*w), $urandom, 1'b1);
    for (int w = 0; w < 32; w++)  issue(1, 1'b1, 3'd2, 32'(4*w), $urandom, 1'b1);
    drain();

    issue(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    drain(); chk("lw_10", last_rd[0], 32'hDEADBEEF);
    issue(0, 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b1);
    issue(0, 1'b1, 3'd0, 32'h21, 32'h000000AA, 1'b1);
    issue(0, 1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
    drain(); chk("lw_20_after_sb", last_rd[0], 32'h1122AA44);
    issue(0, 1'b0, 3'd0, 32'h21, 32'h0, 1'b1);
    drain(); chk("lb_21", last_rd[0], 32'hFFFFFFAA);
    issue(0, 1'b0, 3'd4, 32'h21, 32'h0, 1'b1);
    drain(); chk("lbu_21", last_rd[0], 32'h000000AA);
    issue(0, 1'b1, 3'd1, 32'h32, 32'h00008001, 1'b1);
    issue(0, 1'b0, 3'd1, 32'h32, 32'h0, 1'b1);
    drain(); chk("lh_32", last_rd[0], 32'hFFFF8001);
    issue(0, 1'b0, 3'd5, 32'h32, 32'h0, 1'b1);
    drain(); chk("lhu_32", last_rd[0], 32'h00008001);
    issue(0, 1'b0, 3'd2, 32'h30, 32'h0, 1'b1);
    drain(); chk("lw_30_upper", {16'b0, last_rd[0][31:16]}, 32'h00008001);
    issue(0, 1'b0, 3'd2, 32'h22, 32'h0, 1'b1);
    drain(); chk("lw_22_err", {31'b0, last_err[0]}, 32'd1); chk("lw_22_rdata", last_rd[0], 32'd0);
    issue(0, 1'b1, 3'd1, 32'h41, 32'h5555, 1'b1);
    drain(); chk("sh_41_err", {31'b0, last_err[0]}, 32'd1);
    issue(0, 1'b0, 3'd3, 32'h40, 32'h0, 1'b1);
    drain(); chk("f3_011_err", {31'b0, last_err[0]}, 32'd1);
    issue(0, 1'b0, 3'd2, 32'h40, 32'h0, 1'b1);
    issue(0, 1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 1'b1);
    issue(0, 1'b0, 3'd2, 32'h000, 32'h0, 1'b1);
    drain(); chk("wrap_lw_0", last_rd[0], 32'hCAFEF00D);

    // LATENCY=3 instance: back-to-back spacing, then reset during BUSY.
    rc1.delete();
    issue(1, 1'b1, 3'd0, 32'h05, 32'h000000C3, 1'b1);
    issue(1, 1'b0, 3'd2, 32'h04, 32'h0, 1'b1);
    issue(1, 1'b0, 3'd0, 32'h05, 32'h0, 1'b1);
    drain();
    chk("b2b_resp_count", rc1.size(), 3);
    if (rc1.size() == 3) begin
      chk("b2b_spacing_a", rc1[1] - rc1[0], 5);
      chk("b2b_spacing_b", rc1[2] - rc1[1], 5);
    end
    chk("lb_05_lat3", last_rd[1], 32'hFFFFFFC3);
    issue(1, 1'b1, 3'd2, 32'h50, 32'h0BADF00D, 1'b1);
    drain();
    n0 = nresp[1];
    skip_run = 1'b1;
    issue(1, 1'b1, 3'd2, 32'h50, 32'h12345678, 1'b0);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (8) @(negedge clk);
    skip_run = 1'b0;
    chk("rst_no_resp", nresp[1], n0);
    issue(1, 1'b0, 3'd2, 32'h50, 32'h0, 1'b1);
    drain(); chk("rst_store_dropped", last_rd[1], 32'h0BADF00D);

    for (int k = 0; k < 300; k++) begin
      rwe = 1'($urandom_range(0, 1));
      rf  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                         : (rwe ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)]);
      ra  = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      rw  = $urandom;
      issue(0, rwe, rf, ra, rw, 1'b1);
    end
    drain();

`ifdef DMEM_PERF_CNT_EN
    repeat (2) @(negedge clk);
    chk("perf_loads", p_ld[0], exp_ld);
    chk("perf_stores", p_st[0], exp_st);
    chk("perf_errs", p_er[0], exp_er);
    chk("perf_stall_cycles", p_sc[0], exp_sc);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
